// File: rtl/x6_fifo_writer.sv
// rtl/x6_fifo_writer.sv - six-channel FIFO write-side controller with 2-entry skid buffers
module x6_fifo_writer #(
  parameter int DW      = 16,
  parameter int GAP_CYC = 1
) (
  input  logic            clk,
  input  logic            init,
  input  logic [5:0]      push,
  input  logic [6*DW-1:0] din,
  output logic [5:0]      pak,
  input  logic [5:0]      ff_b,
  input  logic [5:0]      paf_b,
  output logic [5:0]      wren_b,
  output logic [6*DW-1:0] fifo_d,
  output logic [5:0]      ovf,
  output logic            busy
);

  typedef enum logic {RUN, GAP} state_t;

  // Counter loads GAP_CYC-1 so the GAP state spans exactly GAP_CYC issue-blocked edges.
  localparam logic [1:0] GAP_LOAD = 2'(GAP_CYC - 1);

  logic [5:0] nonempty;

  for (genvar k = 0; k < 6; k++) begin : g_ch
    state_t          state, state_nx;
    logic [1:0]      gcnt, gcnt_nx;
    logic [1:0]      count;
    logic [DW-1:0]   head, tail;
    logic            accept, issue;
    logic            wren_r, ovf_r;
    logic [DW-1:0]   fd_r;
    logic [DW-1:0]   word;

    assign word        = din[k*DW +: DW];
    assign pak[k]      = (count != 2'd2);
    assign accept      = push[k] & pak[k];
    assign issue       = (count != 2'd0) & ff_b[k] & (state == RUN);
    assign nonempty[k] = (count != 2'd0);

    assign wren_b[k]           = wren_r;
    assign fifo_d[k*DW +: DW]  = fd_r;
    assign ovf[k]              = ovf_r;

    always_comb begin
      state_nx = state;
      gcnt_nx  = gcnt;
      case (state)
        RUN: begin
          if (issue && !paf_b[k]) begin
            state_nx = GAP;
            gcnt_nx  = GAP_LOAD;
          end
        end
        GAP: begin
          if (gcnt == 2'd0) state_nx = RUN;
          else              gcnt_nx  = gcnt - 2'd1;
        end
        default: state_nx = RUN;
      endcase
    end

    always_ff @(posedge clk or posedge init) begin
      if (init) begin
        state <= RUN;
        gcnt  <= 2'd0;
      end else begin
        state <= state_nx;
        gcnt  <= gcnt_nx;
      end
    end

    always_ff @(posedge clk or posedge init) begin
      if (init) begin
        count  <= 2'd0;
        head   <= '0;
        tail   <= '0;
        wren_r <= 1'b1;
        fd_r   <= '0;
        ovf_r  <= 1'b0;
      end else begin
        count  <= count + {1'b0, accept} - {1'b0, issue};
        wren_r <= ~issue;
        if (push[k] && !pak[k]) ovf_r <= 1'b1;
        if (issue) begin
          fd_r <= head;
          // Pop: the tail moves up at count 2; at count 1 a same-edge accept lands in the head.
          if (count == 2'd2) head <= tail;
          else if (accept)   head <= word;
        end else if (accept) begin
          if (count == 2'd0) head <= word;
          else               tail <= word;
        end
      end
    end
  end

  assign busy = |nonempty;

endmodule

// File: tb/tb_x6_fifo_writer.sv
// tb/tb_x6_fifo_writer.sv - directed self-checking bench for x6_fifo_writer
module tb_x6_fifo_writer;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            init;
  logic [5:0]      push;
  logic [6*DW-1:0] din;
  logic [5:0]      pak;
  logic [5:0]      ff_b;
  logic [5:0]      paf_b;
  logic [5:0]      wren_b;
  logic [6*DW-1:0] fifo_d;
  logic [5:0]      ovf;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  x6_fifo_writer #(.DW(DW), .GAP_CYC(2)) dut (
    .clk(clk), .init(init), .push(push), .din(din), .pak(pak),
    .ff_b(ff_b), .paf_b(paf_b), .wren_b(wren_b), .fifo_d(fifo_d),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    init = 1'b1;
    push = '0;
    din  = '0;
    ff_b = 6'h3F;
    paf_b = 6'h3F;
    step();
    init = 1'b0;
  endtask

  logic [DW-1:0] a_words [4] = '{16'hA000, 16'hA111, 16'hA222, 16'hA333};
  logic [8:0]    pat4;
  logic [DW-1:0] q [6][$];
  logic [5:0]    ffs;
  logic [DW-1:0] w;
  int            tag_cnt;

  initial begin
    do_reset();

    // 1: reset, including an asynchronous init while ch0 is writing
    check("rst_wren", wren_b, 6'h3F);
    check("rst_pak", pak, 6'h3F);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    push[0] = 1'b1; din[0 +: DW] = 16'h1234;
    step();
    din[0 +: DW] = 16'h5678;
    step();
    check("pre_init_wren0", wren_b[0], 0);
    #2 init = 1'b1;
    #1;
    check("async_wren", wren_b, 6'h3F);
    check("async_fd", fifo_d[0 +: DW], 0);
    check("async_busy", busy, 0);
    check("async_pak", pak, 6'h3F);
    push = '0;
    init = 1'b0;
    step();
    check("post_init_wren", wren_b, 6'h3F);

    // 2: ch0 stream of four words
    do_reset();
    push[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[0 +: DW] = a_words[i];
      step();
      if (i == 0) check("s_first_idle", wren_b[0], 1);
      else begin
        check("s_wren", wren_b[0], 0);
        check("s_data", fifo_d[0 +: DW], a_words[i-1]);
      end
    end
    push[0] = 1'b0;
    step();
    check("s_wren_last", wren_b[0], 0);
    check("s_data_last", fifo_d[0 +: DW], a_words[3]);
    step();
    check("s_end_idle", wren_b[0], 1);
    check("s_busy", busy, 0);

    // 3: ch2 held full
    do_reset();
    ff_b[2] = 1'b0;
    push[2] = 1'b1;
    din[2*DW +: DW] = 16'hB000;
    step();
    check("f_pak_1", pak[2], 1);
    din[2*DW +: DW] = 16'hB111;
    step();
    check("f_pak_full", pak[2], 0);
    check("f_ovf_before", ovf[2], 0);
    din[2*DW +: DW] = 16'hB222;
    step();
    check("f_ovf", ovf[2], 1);
    check("f_nowr3", wren_b[2], 1);
    push[2] = 1'b0;
    step();
    check("f_nowr4", wren_b[2], 1);
    step();
    check("f_nowr5", wren_b[2], 1);
    ff_b[2] = 1'b1;
    step();
    check("f_wr0", wren_b[2], 0);
    check("f_d0", fifo_d[2*DW +: DW], 16'hB000);
    step();
    check("f_wr1", wren_b[2], 0);
    check("f_d1", fifo_d[2*DW +: DW], 16'hB111);
    step();
    check("f_idle", wren_b[2], 1);
    check("f_ovf_sticky", ovf[2], 1);
    check("f_other_ovf", ovf & 6'h3B, 0);

    // 4: ch3 almost full, GAP_CYC=2 -> strobe, 2 idle, strobe ...
    do_reset();
    ff_b[3] = 1'b0;
    paf_b[3] = 1'b0;
    push[3] = 1'b1;
    din[3*DW +: DW] = 16'hC000;
    step();
    din[3*DW +: DW] = 16'hC111;
    step();
    push[3] = 1'b0;
    ff_b[3] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      pat4[i] = wren_b[3];
      if (i == 0) begin
        check("g_d0", fifo_d[3*DW +: DW], 16'hC000);
        push[3] = 1'b1;
        din[3*DW +: DW] = 16'hC222;
      end else begin
        push[3] = 1'b0;
      end
      if (i == 3) check("g_d1", fifo_d[3*DW +: DW], 16'hC111);
      if (i == 6) check("g_d2", fifo_d[3*DW +: DW], 16'hC222);
    end
    check("g_pattern", pat4, 9'b110_110_110);

    // 6: count==1 with same-edge accept and issue
    do_reset();
    ff_b[1] = 1'b0;
    push[1] = 1'b1;
    din[1*DW +: DW] = 16'hD000;
    step();
    ff_b[1] = 1'b1;
    din[1*DW +: DW] = 16'hD111;
    step();
    check("sim_wr0", wren_b[1], 0);
    check("sim_d0", fifo_d[1*DW +: DW], 16'hD000);
    check("sim_pak", pak[1], 1);
    push[1] = 1'b0;
    step();
    check("sim_wr1", wren_b[1], 0);
    check("sim_d1", fifo_d[1*DW +: DW], 16'hD111);
    check("sim_busy", busy, 0);

    // 5: all channels, random flags, scoreboard
    do_reset();
    tag_cnt = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      for (int k = 0; k < 6; k++) begin
        if (cyc < 260) begin
          ff_b[k]  = ($urandom_range(0, 3) != 0);
          paf_b[k] = ($urandom_range(0, 3) != 0);
        end else begin
          ff_b[k]  = 1'b1;
          paf_b[k] = 1'b1;
        end
        if (cyc < 250 && pak[k] && $urandom_range(0, 1) == 1) begin
          w = {4'(k), 12'(tag_cnt)};
          tag_cnt++;
          push[k] = 1'b1;
          din[k*DW +: DW] = w;
          q[k].push_back(w);
        end else begin
          push[k] = 1'b0;
        end
      end
      ffs = ff_b;
      step();
      for (int k = 0; k < 6; k++) begin
        if (!wren_b[k]) begin
          check("c_ff_gate", ffs[k], 1);
          if (q[k].size() == 0) check("c_extra_write", k, 99);
          else check("c_data", fifo_d[k*DW +: DW], q[k].pop_front());
        end
      end
    end
    for (int k = 0; k < 6; k++) check("c_drained", q[k].size(), 0);
    check("c_busy", busy, 0);
    check("c_ovf", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
